// File: rtl/pipe_event_counter.sv
// ---------------------------------------------------------------------------
// pipe_event_counter
//
// Performance/event counter block for the pipelined CPU. It counts run
// cycles, load-use stall bubbles, control-hazard flushes and retired
// instructions while the core is running. It raises a sticky done flag once a
// programmable cycle budget is used up, and exposes one counter, chosen by
// sel_i, on a registered read port.
//
// Parameters:
//   WIDTH       width of every counter and of cnt_o
//   MAX_CYCLES  run-cycle budget; done_o asserts when the cycle count
//               reaches this value (must be >= 1)
//
// Ports:
//   clk_i      clock; all state updates happen on its rising edge
//   rst_i      asynchronous active-low reset
//   start_i    CPU start; high enables counting
//   stall_i    hazard unit inserted a bubble this cycle
//   flush_i    IF/ID flush asserted this cycle
//   retire_i   a valid non-bubble instruction wrote back this cycle
//   clear_i    synchronous clear of all counters and of done
//   sel_i      read select: 0 cycles, 1 stalls, 2 flushes, 3 retired
//   cnt_o      registered value of the selected counter (one-cycle latency)
//   done_o     sticky: cycle budget exhausted
//   running_o  high while in RUN state
// ---------------------------------------------------------------------------
module pipe_event_counter #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             clear_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             done_o,
    output logic             running_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Counter 0 = cycles, 1 = stalls, 2 = flushes, 3 = retired.
    logic [3:0][WIDTH-1:0] cnt_reg;
    logic [3:0][WIDTH-1:0] cnt_next;

    logic [3:0]       event_vec;
    logic             count_en;
    logic [WIDTH-1:0] cycle_inc;
    logic             budget_hit;

    // The cycle counter counts on every RUN edge, so its event bit is tied high.
    assign event_vec = {retire_i, flush_i, stall_i, 1'b1};

    // Saturating increment of the cycle counter, used only for the budget
    // check. It is taken straight from the register so that it never depends
    // on the next-state logic.
    assign cycle_inc = (cnt_reg[0] == '1) ? cnt_reg[0] : cnt_reg[0] + 1'b1;

    // The comparison is done at 64 bits. When the budget cannot be
    // represented in WIDTH bits, it is never reached: the counter saturates
    // first.
    assign budget_hit = (64'(cycle_inc) == 64'(MAX_CYCLES));

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        count_en   = 1'b0;
        if (clear_i) begin
            state_next = start_i ? RUN : IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    count_en = 1'b1;
                    // The budget check takes priority over a pause request.
                    if (budget_hit) begin
                        state_next = DONE;
                    end else if (!start_i) begin
                        state_next = IDLE;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Per-counter update: clear wins, otherwise a saturating increment when
    // counting is enabled and the counter's own event is present.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            assign cnt_next[gi] =
                clear_i                                               ? '0 :
                (count_en && event_vec[gi] && (cnt_reg[gi] != '1))    ? cnt_reg[gi] + 1'b1 :
                                                                        cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cnt_o     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // The read port shows post-update values. A clear edge therefore
            // reads back 0.
            cnt_o     <= cnt_next[sel_i];
        end
    end

    assign running_o = (state_reg == RUN);
    assign done_o    = (state_reg == DONE);

endmodule

// File: tb/tb_pipe_event_counter.sv
// ---------------------------------------------------------------------------
// tb_pipe_event_counter
//
// Self-checking bench for pipe_event_counter. Two instances share one
// stimulus stream:
//   - d0 uses the defaults (WIDTH = 32, MAX_CYCLES = 30);
//   - d1 is narrow (WIDTH = 4, MAX_CYCLES = 20), so saturation is exercised.
//
// A behavioural model tracks every counter as a plain integer and predicts
// cnt_o, done_o and running_o after each rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_event_counter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       stall_i;
    logic       flush_i;
    logic       retire_i;
    logic       clear_i;
    logic [1:0] sel_i;

    logic [31:0] cnt0;
    logic        done0;
    logic        run0;
    logic [3:0]  cnt1;
    logic        done1;
    logic        run1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk_i = ~clk_i;

    pipe_event_counter #(.WIDTH(32), .MAX_CYCLES(30)) u_d0 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .retire_i  (retire_i),
        .clear_i   (clear_i),
        .sel_i     (sel_i),
        .cnt_o     (cnt0),
        .done_o    (done0),
        .running_o (run0)
    );

    pipe_event_counter #(.WIDTH(4), .MAX_CYCLES(20)) u_d1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .retire_i  (retire_i),
        .clear_i   (clear_i),
        .sel_i     (sel_i),
        .cnt_o     (cnt1),
        .done_o    (done1),
        .running_o (run1)
    );

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    longint m_cnt   [2][4];
    longint m_out   [2];
    int     m_state [2];
    longint m_limit [2] = '{64'd4294967295, 64'd15};
    longint m_max   [2] = '{64'd30, 64'd20};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
            m_out[d]   = 0;
            m_state[d] = M_IDLE;
        end
    endtask

    function automatic longint sat_add(longint v, longint lim, logic ev);
        if (ev && v < lim) return v + 1;
        return v;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (clear_i) begin
                for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
                m_state[d] = start_i ? M_RUN : M_IDLE;
            end else if (m_state[d] == M_IDLE) begin
                if (start_i) m_state[d] = M_RUN;
            end else if (m_state[d] == M_RUN) begin
                m_cnt[d][0] = sat_add(m_cnt[d][0], m_limit[d], 1'b1);
                m_cnt[d][1] = sat_add(m_cnt[d][1], m_limit[d], stall_i);
                m_cnt[d][2] = sat_add(m_cnt[d][2], m_limit[d], flush_i);
                m_cnt[d][3] = sat_add(m_cnt[d][3], m_limit[d], retire_i);
                if (m_cnt[d][0] == m_max[d]) m_state[d] = M_DONE;
                else if (!start_i)           m_state[d] = M_IDLE;
            end
            m_out[d] = m_cnt[d][sel_i];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("d0_cnt",  longint'(cnt0),  m_out[0]);
        chk("d0_done", longint'(done0), longint'(m_state[0] == M_DONE));
        chk("d0_run",  longint'(run0),  longint'(m_state[0] == M_RUN));
        chk("d1_cnt",  longint'(cnt1),  m_out[1]);
        chk("d1_done", longint'(done1), longint'(m_state[1] == M_DONE));
        chk("d1_run",  longint'(run1),  longint'(m_state[1] == M_RUN));
    endtask

    // Called at a falling edge with inputs already driven. It advances one
    // rising edge, checks the outputs, and returns at the next falling edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_step();
        #1;
        cyc++;
        check_outputs();
        $display("cyc=%0d rst=%b st=%b ev=%b%b%b clr=%b sel=%0d | d0 cnt=%0d done=%b run=%b | d1 cnt=%0d done=%b run=%b",
                 cyc, rst_i, start_i, stall_i, flush_i, retire_i, clear_i, sel_i,
                 cnt0, done0, run0, cnt1, done1, run1);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic st, input logic sl, input logic fl,
                         input logic rt, input logic cl, input logic [1:0] sl_sel);
        start_i  = st;
        stall_i  = sl;
        flush_i  = fl;
        retire_i = rt;
        clear_i  = cl;
        sel_i    = sl_sel;
    endtask

    // Reset is asserted between edges. The outputs must drop without waiting
    // for a clock edge.
    task automatic async_reset();
        rst_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        $display("async reset asserted at %0t | d0 cnt=%0d done=%b run=%b | d1 cnt=%0d",
                 $time, cnt0, done0, run0, cnt1);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        model_reset();
        @(negedge clk_i);
        check_outputs();
        tick();
        rst_i = 1'b1;

        // Start with no events: cycles climb to the budget and freeze there.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 34; i++) tick();

        // DONE freeze: stall pulses are ignored.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
            tick();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
            tick();
        end

        // Clear with start held high: restart straight into RUN.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();

        // Simultaneous events for 3 cycles, then read each counter back.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) tick();
        for (int s = 1; s < 4; s++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'(s));
            tick();
        end

        // Pause: RUN 5 cycles, start low for 4 with stall pulses, resume for 2.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'(i % 2 == 0), 1'b0, 1'b0, 1'b0, 2'd1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        tick();

        // Saturation: retire held high. d1 stops at 15 and never reaches its
        // budget of 20.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
        tick();
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'(i % 2 == 0 ? 3 : 0));
            tick();
        end

        // Async reset mid-run at cycle 12, then restart.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 12; i++) tick();
        async_reset();
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
            end else begin
                drive(1'($urandom_range(0, 9) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 24) == 0),
                      2'($urandom_range(0, 3)));
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_event_counter.md
Name: pipe_event_counter

Overview:
Performance and event counter block instantiated inside the pipelined CPU, next to the hazard-detection and flush logic.
- Counts run cycles, load-use stall bubbles, control-hazard flushes and retired instructions.
- Raises a sticky done flag after a programmable cycle budget, which the bench uses as its stop condition.
- Exposes one selected counter on a registered read port, so the bench does not have to probe internal signals.

Parameters:
WIDTH, 32, width of every counter and of cnt_o
MAX_CYCLES, 30, run-cycle budget; done_o asserts when the cycle counter reaches this value (must be >= 1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  CPU start; high enables counting
stall_i  input  1  hazard unit inserted a bubble this cycle
flush_i  input  1  IF/ID flush asserted this cycle (branch taken or jump)
retire_i  input  1  a valid non-bubble instruction wrote back this cycle
clear_i  input  1  synchronous clear of all counters and of done
sel_i  input  2  read select: 0 cycles, 1 stalls, 2 flushes, 3 retired
cnt_o  output  WIDTH  registered value of the selected counter
done_o  output  1  sticky: cycle budget exhausted
running_o  output  1  high while in RUN state

Behaviour:
- Reset (rst_i low, asynchronous): all four counters = 0, cnt_o = 0, done_o = 0, running_o = 0, state = IDLE. Reset overrides everything and may assert mid-RUN.
- States: IDLE, RUN, DONE; running_o = (state == RUN); done_o = (state == DONE).
- IDLE:
  - Edge with start_i = 1 -> RUN. No counting on this edge.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - cycle += 1.
  - stall += 1 if stall_i; flush += 1 if flush_i; retired += 1 if retire_i.
  - The three event counters are independent; simultaneous inputs each count.
- RUN exits:
  - If the new cycle value equals MAX_CYCLES -> DONE (the counts of that edge are kept).
  - Else if start_i = 0 on the edge -> IDLE. That edge still counts as a RUN edge; this is a pause, and counters hold while in IDLE.
  - Budget check has priority over start_i = 0.
- DONE: counters frozen; input events ignored; state held until clear_i or reset. start_i has no effect.
- clear_i (synchronous) has priority over all state and count updates except reset:
  - All counters -> 0.
  - State -> RUN if start_i = 1, else IDLE.
  - No counting on the clear edge.
- Saturation: any counter at all-ones holds; it never wraps.
- Read port: every edge, cnt_o <= counter[sel_i] with post-update values (the value being written on that edge), giving a one-cycle latency from sel_i.
  - On a clear edge, cnt_o <= 0.

Test Plan:
- Reset then start: rst_i low 1 cycle, start_i = 1, no events, sel_i = 0 -> running_o high after first edge; cnt_o = 1,2,3... on successive edges; done_o rises on the edge where cycle = 30 and stays high; cycle frozen at 30 thereafter.
- Simultaneous events: in RUN, drive stall_i = flush_i = retire_i = 1 for 3 cycles, then 0 -> stalls = flushes = retired = 3, verified by reading sel_i = 1, 2, 3 with a one-cycle latency.
- Pause: RUN 5 cycles, drop start_i for 4 cycles while pulsing stall_i, raise again for 2 cycles -> cycles = 7 (the edge sampling start_i = 0 counts), with resume edge not counted; stalls count only stall_i pulses on RUN edges.
- DONE freeze and clear: after done_o, pulse stall_i 5 times -> stalls unchanged. Assert clear_i with start_i = 1 -> next edge: all counters 0, done_o = 0, running_o = 1, cnt_o = 0.
- Async reset mid-run: at cycle 12, pull rst_i low between edges -> outputs go to 0 immediately, without waiting for a clock edge; after release with start_i = 1 -> IDLE then RUN, cycle restarts from 1.
- Saturation (WIDTH = 4, MAX_CYCLES = 20): hold retire_i = 1 -> retired stops at 15 while cycle advances; budget of 20 exceeds the 4-bit range of 15, so cycle saturates at 15 and done_o is never asserted.
